instr_fetch: RTL

//   Instruction fetch unit: the reader of prog_mem. Owns the program counter (PC) and

---
 rtl/cpu_defs.sv | 27 ++
 rtl/instr_fetch.sv | 119 +++++++++++
 2 files changed

// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs : shared widths, opcode field location and fetch state encoding
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_defs;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 17;

  // Opcode field lives in the top five bits of the instruction word
  localparam int OPC_HI = 16;
  localparam int OPC_LO = 12;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] HALT_OP = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch : program counter, prog_mem address drive and instruction
//               register with stall, redirect, HALT and wrap handling
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import cpu_defs::*;
#(
  parameter int                ADDR_W_P  = ADDR_W,
  parameter int                INSTR_W_P = INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter logic [OPC_W-1:0]  HALT_OPC  = HALT_OP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_run,
  input  logic                 i_stall,
  input  logic                 i_jump_valid,
  input  logic [ADDR_W_P-1:0]  i_jump_addr,
  output logic [ADDR_W_P-1:0]  o_pm_addr,
  input  logic [INSTR_W_P-1:0] i_pm_data,
  output logic [INSTR_W_P-1:0] o_ir,
  output logic [ADDR_W_P-1:0]  o_ir_pc,
  output logic                 o_ir_valid,
  output logic                 o_halted,
  output logic                 o_wrapped
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_W_P-1:0]   r_pc;
  logic [INSTR_W_P-1:0]  r_ir;
  logic [ADDR_W_P-1:0]   r_ir_pc;
  logic                  r_ir_valid;
  logic                  r_halted;
  logic                  r_wrapped;
  logic                  w_jump;
  logic                  w_fetch;
  logic                  w_is_halt;

  assign w_is_halt = (i_pm_data[OPC_HI:OPC_LO] == HALT_OPC);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; a redirect outranks stall/run and is ignored in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_jump      = 1'b0;
    w_fetch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_run) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_jump_valid) begin
          w_jump = 1'b1;
        end else if (i_run && !i_stall) begin
          w_fetch = 1'b1;
          if (w_is_halt) w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (i_jump_valid) begin
          w_jump      = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // PC, instruction register and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_wrapped  <= 1'b0;
    end else begin
      r_wrapped <= 1'b0;
      if (w_jump) begin
        // The word already presented for the old PC is discarded (one bubble)
        r_pc       <= i_jump_addr;
        r_ir_valid <= 1'b0;
        r_halted   <= 1'b0;
      end else if (w_fetch) begin
        r_ir       <= i_pm_data;
        r_ir_pc    <= r_pc;
        r_ir_valid <= 1'b1;
        // A HALT word leaves the PC pointing at itself
        if (!w_is_halt) begin
          r_pc      <= r_pc + 1'b1;
          r_wrapped <= (r_pc == '1);
        end
      end else if (r_state == ST_HALT) begin
        r_ir_valid <= 1'b0;
        r_halted   <= 1'b1;
      end
    end
  end

  assign o_pm_addr  = r_pc;
  assign o_ir       = r_ir;
  assign o_ir_pc    = r_ir_pc;
  assign o_ir_valid = r_ir_valid;
  assign o_halted   = r_halted;
  assign o_wrapped  = r_wrapped;

endmodule

`default_nettype wire
